// File: rtl/final_layer_chunked_argmax_if.sv
// Start/result handshake and weight-memory read port of the chunked argmax classifier.
// The master side is the classifier; the slave side is the controller plus weight memory.
interface final_layer_chunked_argmax_if #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK_WIDTH = 32
);
  localparam int NUM_CHUNKS = (NUM_INPUTS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int CLASS_W    = $clog2(NUM_CLASSES);
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int SCORE_W    = $clog2(NUM_INPUTS + 1);

  logic                   start;
  logic [NUM_INPUTS-1:0]  data_in;
  logic                   w_rd_en;
  logic [CLASS_W-1:0]     w_rd_class;
  logic [CHUNK_W-1:0]     w_rd_chunk;
  logic [CHUNK_WIDTH-1:0] w_rd_data;
  logic                   busy;
  logic                   done;
  logic [CLASS_W-1:0]     answer;
  logic [SCORE_W-1:0]     max_score;

  modport master (
    input  start, data_in, w_rd_data,
    output w_rd_en, w_rd_class, w_rd_chunk, busy, done, answer, max_score
  );

  modport slave (
    output start, data_in, w_rd_data,
    input  w_rd_en, w_rd_class, w_rd_chunk, busy, done, answer, max_score
  );
endinterface

// File: rtl/final_layer_chunked_argmax.sv
// Final BNN layer: streams class weight rows chunk by chunk, popcounts the matches
// against the latched feature vector and keeps a running argmax over classes.
module final_layer_chunked_argmax #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK_WIDTH = 32,
  parameter int XNOR_MODE   = 1
) (
  input logic                         clock,
  input logic                         reset,
  final_layer_chunked_argmax_if.master bus
);
  localparam int NUM_CHUNKS = (NUM_INPUTS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CLASS_W    = $clog2(NUM_CLASSES);
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int SCORE_W    = $clog2(NUM_INPUTS + 1);
  localparam int POP_W      = $clog2(CHUNK_WIDTH + 1);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  // Bits at or beyond NUM_INPUTS in the last chunk are padding and never score.
  function automatic logic [PAD_W-1:0] validMask();
    logic [PAD_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_INPUTS; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [PAD_W-1:0] VALID_MASK = validMask();

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_RESOLVE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 w_accept;
  logic                 w_rdEn;
  logic                 w_lastAddr;

  logic [PAD_W-1:0]     r_data;
  logic [CLASS_W-1:0]   r_rdClass;
  logic [CHUNK_W-1:0]   r_rdChunk;

  logic                 r_accValid;
  logic [CLASS_W-1:0]   r_accClass;
  logic [CHUNK_W-1:0]   r_accChunk;

  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   r_best;
  logic [CLASS_W-1:0]   r_bestClass;

  logic                 r_done;
  logic [CLASS_W-1:0]   r_answer;
  logic [SCORE_W-1:0]   r_maxScore;

  logic [CHUNK_WIDTH-1:0] w_dataChunk;
  logic [CHUNK_WIDTH-1:0] w_maskChunk;
  logic [CHUNK_WIDTH-1:0] w_match;
  logic [POP_W-1:0]       w_pop;
  logic [SCORE_W-1:0]     w_classSum;
  logic                   w_classEnd;
  logic                   w_takeNew;
  logic [SCORE_W-1:0]     w_newBest;
  logic [CLASS_W-1:0]     w_newBestClass;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Start is only honoured in IDLE, so pulses while busy (including RESOLVE) are dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_rdEn      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_FETCH: begin
        w_rdEn = 1'b1;
        if (w_lastAddr) w_nextState = S_DRAIN;
      end
      S_DRAIN:   w_nextState = S_RESOLVE;
      S_RESOLVE: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  assign w_lastAddr = (r_rdClass == LAST_CLASS) && (r_rdChunk == LAST_CHUNK);

  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_rdClass <= '0;
      r_rdChunk <= '0;
    end else if (w_rdEn) begin
      if (r_rdChunk == LAST_CHUNK) begin
        r_rdChunk <= '0;
        r_rdClass <= r_rdClass + 1'b1;
      end else begin
        r_rdChunk <= r_rdChunk + 1'b1;
      end
    end
  end

  // The address issued this cycle tags the weight chunk that arrives next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data     <= '0;
      r_accValid <= 1'b0;
      r_accClass <= '0;
      r_accChunk <= '0;
    end else begin
      if (w_accept) r_data <= PAD_W'(bus.data_in);
      r_accValid <= w_rdEn;
      r_accClass <= r_rdClass;
      r_accChunk <= r_rdChunk;
    end
  end

  always_comb begin
    w_dataChunk = r_data[int'(r_accChunk) * CHUNK_WIDTH +: CHUNK_WIDTH];
    w_maskChunk = VALID_MASK[int'(r_accChunk) * CHUNK_WIDTH +: CHUNK_WIDTH];
    if (XNOR_MODE != 0) w_match = ~(w_dataChunk ^ bus.w_rd_data) & w_maskChunk;
    else                w_match = (w_dataChunk & bus.w_rd_data) & w_maskChunk;
    w_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) w_pop = w_pop + POP_W'(w_match[i]);
  end

  // Chunk 0 starts a fresh class, so the accumulator restarts without a bubble.
  assign w_classSum     = ((r_accChunk == '0) ? '0 : r_score) + SCORE_W'(w_pop);
  assign w_classEnd     = r_accValid && (r_accChunk == LAST_CHUNK);
  assign w_takeNew      = (r_accClass == '0) || (w_classSum > r_best);
  assign w_newBest      = w_takeNew ? w_classSum : r_best;
  assign w_newBestClass = w_takeNew ? r_accClass : r_bestClass;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_score     <= '0;
      r_best      <= '0;
      r_bestClass <= '0;
    end else if (r_accValid) begin
      r_score <= w_classSum;
      if (w_classEnd) begin
        r_best      <= w_newBest;
        r_bestClass <= w_newBestClass;
      end
    end
  end

  // DRAIN accumulates the final chunk, so the result is published on entry to RESOLVE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_answer   <= '0;
      r_maxScore <= '0;
    end else begin
      r_done <= (r_state == S_DRAIN);
      if (r_state == S_DRAIN) begin
        r_answer   <= w_newBestClass;
        r_maxScore <= w_newBest;
      end
    end
  end

  assign bus.w_rd_en    = w_rdEn;
  assign bus.w_rd_class = r_rdClass;
  assign bus.w_rd_chunk = r_rdChunk;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.answer     = r_answer;
  assign bus.max_score  = r_maxScore;

endmodule

// File: tb/tb_final_layer_chunked_argmax.sv
// Bench for final_layer_chunked_argmax: default XNOR configuration plus a small AND configuration,
// checked every cycle against a cycle-count/argmax model and pinned by hand-computed cases.
module tb_final_layer_chunked_argmax;
  localparam int NI_A = 196, NC_A = 10, CW_A = 32, NCH_A = 7, N_A = 70, PW_A = 224;
  localparam int NI_B = 40,  NC_B = 4,  CW_B = 16, NCH_B = 3, N_B = 12, PW_B = 48;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  final_layer_chunked_argmax_if #(.NUM_INPUTS(NI_A), .NUM_CLASSES(NC_A), .CHUNK_WIDTH(CW_A)) busA();
  final_layer_chunked_argmax_if #(.NUM_INPUTS(NI_B), .NUM_CLASSES(NC_B), .CHUNK_WIDTH(CW_B)) busB();

  final_layer_chunked_argmax #(.NUM_INPUTS(NI_A), .NUM_CLASSES(NC_A), .CHUNK_WIDTH(CW_A), .XNOR_MODE(1))
    dutA (.clock(clock), .reset(reset), .bus(busA));
  final_layer_chunked_argmax #(.NUM_INPUTS(NI_B), .NUM_CLASSES(NC_B), .CHUNK_WIDTH(CW_B), .XNOR_MODE(0))
    dutB (.clock(clock), .reset(reset), .bus(busB));

  logic [PW_A-1:0] memA [NC_A];
  logic [PW_B-1:0] memB [NC_B];

  int nChecks = 0;
  int nPass   = 0;
  logic armed = 1'b0;
  int runA = -1, runB = -1;
  int expAnsA = 0, expScA = 0, pendAnsA = 0, pendScA = 0;
  int expAnsB = 0, expScB = 0, pendAnsB = 0, pendScB = 0;
  int rdCntA = 0, doneCntA = 0;
  int doneCyc;
  logic [PW_A-1:0] tmpA;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference argmax: full-vector match count per class, strictly-greater replacement.
  function automatic void modelA(input logic [NI_A-1:0] d, output int ans, output int sc);
    int s;
    ans = 0; sc = -1;
    for (int c = 0; c < NC_A; c++) begin
      s = 0;
      for (int i = 0; i < NI_A; i++) if (d[i] == memA[c][i]) s++;
      if (s > sc) begin sc = s; ans = c; end
    end
  endfunction

  function automatic void modelB(input logic [NI_B-1:0] d, output int ans, output int sc);
    int s;
    ans = 0; sc = -1;
    for (int c = 0; c < NC_B; c++) begin
      s = 0;
      for (int i = 0; i < NI_B; i++) if (d[i] && memB[c][i]) s++;
      if (s > sc) begin sc = s; ans = c; end
    end
  endfunction

  function automatic logic [NI_A-1:0] randA();
    logic [NI_A-1:0] r;
    for (int i = 0; i < NI_A; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [PW_A-1:0] rowA();
    logic [PW_A-1:0] r;
    for (int i = 0; i < PW_A; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Weight memory: one-cycle read latency, garbage when not read.
  always @(posedge clock) begin
    if (busA.w_rd_en) busA.w_rd_data <= memA[busA.w_rd_class][busA.w_rd_chunk * CW_A +: CW_A];
    else              busA.w_rd_data <= 32'($urandom);
    if (busB.w_rd_en) busB.w_rd_data <= memB[busB.w_rd_class][busB.w_rd_chunk * CW_B +: CW_B];
    else              busB.w_rd_data <= CW_B'($urandom);
  end

  // Run tracker: runX is the cycle number within a run (1 = first read cycle), -1 when idle.
  always @(posedge clock) begin
    if (reset) begin
      runA = -1; runB = -1;
      expAnsA = 0; expScA = 0; expAnsB = 0; expScB = 0;
      armed = 1'b1;
    end else begin
      if (runA < 0) begin
        if (busA.start) begin runA = 1; modelA(busA.data_in, pendAnsA, pendScA); end
      end else if (runA == N_A + 2) runA = -1;
      else begin
        runA++;
        if (runA == N_A + 2) begin expAnsA = pendAnsA; expScA = pendScA; end
      end
      if (runB < 0) begin
        if (busB.start) begin runB = 1; modelB(busB.data_in, pendAnsB, pendScB); end
      end else if (runB == N_B + 2) runB = -1;
      else begin
        runB++;
        if (runB == N_B + 2) begin expAnsB = pendAnsB; expScB = pendScB; end
      end
    end
  end

  // Per-cycle compare of both instances against the tracker.
  always @(negedge clock) begin
    if (armed) begin
      if (busA.w_rd_en) rdCntA++;
      if (busA.done) doneCntA++;
      checkOutput("A busy", busA.busy, runA >= 1);
      checkOutput("A done", busA.done, runA == N_A + 2);
      checkOutput("A rd_en", busA.w_rd_en, runA >= 1 && runA <= N_A);
      if (runA >= 1 && runA <= N_A) begin
        checkOutput("A rd_class", busA.w_rd_class, (runA - 1) / NCH_A);
        checkOutput("A rd_chunk", busA.w_rd_chunk, (runA - 1) % NCH_A);
      end
      checkOutput("A answer", busA.answer, expAnsA);
      checkOutput("A max_score", busA.max_score, expScA);
      checkOutput("B busy", busB.busy, runB >= 1);
      checkOutput("B done", busB.done, runB == N_B + 2);
      checkOutput("B rd_en", busB.w_rd_en, runB >= 1 && runB <= N_B);
      if (runB >= 1 && runB <= N_B) begin
        checkOutput("B rd_class", busB.w_rd_class, (runB - 1) / NCH_B);
        checkOutput("B rd_chunk", busB.w_rd_chunk, (runB - 1) % NCH_B);
      end
      checkOutput("B answer", busB.answer, expAnsB);
      checkOutput("B max_score", busB.max_score, expScB);
    end
  end

  // Start in cycle 0; optional extra start pulse and reset pulse at given run cycles.
  task automatic applyStimulus(input logic [NI_A-1:0] d, input int pulseAt, input int resetAt,
                               output int dc);
    @(negedge clock);
    busA.data_in = d;
    busA.start   = 1'b1;
    dc = -1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clock);
      busA.start = (c == pulseAt);
      reset      = (c == resetAt);
      if (c == 1) busA.data_in = randA();
      if (busA.done) begin dc = c; break; end
      if (resetAt > 0 && c == resetAt + 4) break;
    end
    @(negedge clock);
    busA.start = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [NI_B-1:0] d, output int dc);
    @(negedge clock);
    busB.data_in = d;
    busB.start   = 1'b1;
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      busB.start = 1'b0;
      if (c == 1) busB.data_in = NI_B'({$urandom, $urandom});
      if (busB.done) begin dc = c; break; end
    end
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    busA.start = 1'b0; busA.data_in = '0;
    busB.start = 1'b0; busB.data_in = '0;
    for (int c = 0; c < NC_A; c++) memA[c] = '0;
    for (int c = 0; c < NC_B; c++) memB[c] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset answer", busA.answer, 0);
    checkOutput("reset max_score", busA.max_score, 0);
    checkOutput("reset busy", busA.busy, 0);
    checkOutput("reset rd_en", busA.w_rd_en, 0);

    $display("[TB] case 1: single winning class");
    memA[4] = '1;
    applyStimulus('1, 0, 0, doneCyc);
    checkOutput("t1 done cycle", doneCyc, 72);
    checkOutput("t1 answer", busA.answer, 4);
    checkOutput("t1 max_score", busA.max_score, 196);
    checkOutput("t1 busy after", busA.busy, 0);

    $display("[TB] case 2: ramp of scores and read order");
    for (int c = 0; c < NC_A; c++) memA[c] = (PW_A'(1) << (c + 1)) - PW_A'(1);
    rdCntA = 0;
    applyStimulus('1, 0, 0, doneCyc);
    checkOutput("t2 answer", busA.answer, 9);
    checkOutput("t2 max_score", busA.max_score, 10);
    checkOutput("t2 rd_en cycles", rdCntA, 70);

    $display("[TB] case 3: tie resolves to lower class");
    for (int c = 0; c < NC_A; c++) memA[c] = '0;
    memA[2] = '1; memA[7] = '1;
    applyStimulus('1, 0, 0, doneCyc);
    checkOutput("t3 answer", busA.answer, 2);
    checkOutput("t3 max_score", busA.max_score, 196);

    $display("[TB] case 4: pad bits never count");
    for (int c = 0; c < NC_A; c++) memA[c] = '0;
    tmpA = '0; tmpA[0] = 1'b1;
    for (int i = NI_A; i < PW_A; i++) tmpA[i] = 1'b1;
    memA[5] = tmpA;
    memA[3] = PW_A'(3);
    applyStimulus('1, 0, 0, doneCyc);
    checkOutput("t4 answer", busA.answer, 3);
    checkOutput("t4 max_score", busA.max_score, 2);

    $display("[TB] case 5: ignored starts and mid-run reset");
    for (int c = 0; c < NC_A; c++) memA[c] = '0;
    memA[6] = '1;
    doneCntA = 0;
    applyStimulus('1, 10, 0, doneCyc);
    checkOutput("t5 done cycle", doneCyc, 72);
    applyStimulus('1, 72, 0, doneCyc);
    checkOutput("t5 start in done ignored", busA.busy, 0);
    repeat (80) @(negedge clock);
    checkOutput("t5 done pulses", doneCntA, 2);
    checkOutput("t5 answer", busA.answer, 6);
    applyStimulus('1, 0, 30, doneCyc);
    checkOutput("t5 aborted no done", doneCyc, -1);
    checkOutput("t5 reset answer", busA.answer, 0);
    checkOutput("t5 reset max_score", busA.max_score, 0);
    checkOutput("t5 done count", doneCntA, 2);
    applyStimulus('1, 0, 0, doneCyc);
    checkOutput("t5 rerun done cycle", doneCyc, 72);
    checkOutput("t5 rerun answer", busA.answer, 6);

    $display("[TB] case 6: AND mode, small configuration");
    memB[1] = '1;
    memB[2] = 48'h00FF_FFF0_0000;
    applyStimulusB(40'h00_000F_FFFF, doneCyc);
    checkOutput("t6 done cycle", doneCyc, 14);
    checkOutput("t6 answer", busB.answer, 1);
    checkOutput("t6 max_score", busB.max_score, 20);

    $display("[TB] random runs");
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < NC_A; c++) memA[c] = rowA();
      if (k % 2 == 0) memA[$urandom_range(1, NC_A - 1)] = memA[$urandom_range(0, NC_A - 1)];
      applyStimulus((k % 3 == 0) ? '1 : randA(), $urandom_range(2, 72), 0, doneCyc);
      checkOutput("rand A done cycle", doneCyc, N_A + 2);
    end
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < NC_B; c++) memB[c] = PW_B'({$urandom, $urandom});
      applyStimulusB(NI_B'({$urandom, $urandom}), doneCyc);
      checkOutput("rand B done cycle", doneCyc, N_B + 2);
    end

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
